// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer: a psum FIFO and incoming results feed a one-entry
// combine register, which drains into an output FIFO; a small run controller sequences it.
//
// state   | meaning
// IDLE    | waiting for start; mode and len latched on start
// RUN     | accepting results until len have been taken
// DRAIN   | waiting for the combine register to reach the output FIFO
// DONE    | one-cycle end-of-run pulse
module psum_accum_buffer #(
   parameter int PSUM_WIDTH     = 16,
   parameter int PSUM_PAR_WRITE = 1,
   parameter int PSUM_DEPTH     = 16,
   parameter int OUT_PAR_READ   = 1,
   parameter int OUT_DEPTH      = 16,
   parameter int CNT_W          = 8
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   clear,
   input  logic                                   start,
   input  logic [1:0]                             mode,
   input  logic [CNT_W-1:0]                       len,
   input  logic                                   psum_wen,
   input  logic [PSUM_PAR_WRITE*PSUM_WIDTH-1:0]   psum_din,
   output logic                                   psum_full,
   output logic                                   psum_empty,
   input  logic                                   res_valid,
   input  logic [PSUM_WIDTH-1:0]                  res_data,
   output logic                                   res_ready,
   input  logic                                   out_ren,
   output logic [OUT_PAR_READ*(PSUM_WIDTH+1)-1:0] out_dout,
   output logic                                   out_full,
   output logic                                   out_empty,
   output logic                                   busy,
   output logic                                   done
);
   localparam int OW    = PSUM_WIDTH + 1;
   localparam int PS_AW = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
   localparam int PS_CW = $clog2(PSUM_DEPTH + 1);
   localparam int OF_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int OF_CW = $clog2(OUT_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // Pointer advance modulo depth; k never exceeds the depth, so one subtraction suffices.
   function automatic logic [PS_AW-1:0] ps_wrap(input logic [PS_AW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= PSUM_DEPTH) s = s - PSUM_DEPTH;
      return PS_AW'(s);
   endfunction

   function automatic logic [OF_AW-1:0] of_wrap(input logic [OF_AW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= OUT_DEPTH) s = s - OUT_DEPTH;
      return OF_AW'(s);
   endfunction

   state_t                r_state;
   logic [1:0]            r_mode;
   logic [CNT_W-1:0]      r_len;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_pipe_vld;
   logic [OW-1:0]         r_pipe_data;

   logic [PSUM_WIDTH-1:0] r_ps_mem [PSUM_DEPTH];
   logic [PS_AW-1:0]      r_ps_wptr;
   logic [PS_AW-1:0]      r_ps_rptr;
   logic [PS_CW-1:0]      r_ps_cnt;

   logic [OW-1:0]         r_of_mem [OUT_DEPTH];
   logic [OF_AW-1:0]      r_of_wptr;
   logic [OF_AW-1:0]      r_of_rptr;
   logic [OF_CW-1:0]      r_of_cnt;

   logic                  w_ps_push;
   logic                  w_ps_pop;
   logic [PSUM_WIDTH-1:0] w_ps_head;
   logic                  w_of_push;
   logic                  w_of_pop;
   logic                  w_need_ps;
   logic                  w_pipe_drain;
   logic                  w_acc;
   logic [OW-1:0]         w_res_ext;
   logic [OW-1:0]         w_ps_ext;
   logic [OW-1:0]         w_pipe_nxt;

   assign psum_empty = (r_ps_cnt == '0);
   assign psum_full  = (int'(r_ps_cnt) > PSUM_DEPTH - PSUM_PAR_WRITE);
   assign out_full   = (r_of_cnt == OF_CW'(OUT_DEPTH));
   assign out_empty  = (int'(r_of_cnt) < OUT_PAR_READ);
   assign busy       = (r_state == S_RUN) | (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);

   assign w_ps_head    = r_ps_mem[r_ps_rptr];
   assign w_need_ps    = (r_mode == 2'b01) | (r_mode == 2'b10);
   assign w_pipe_drain = r_pipe_vld & ~out_full;

   assign res_ready = ~clear & (r_state == S_RUN) & (~r_pipe_vld | w_pipe_drain) &
                      (r_cnt < r_len) & (~w_need_ps | ~psum_empty);

   assign w_acc     = res_valid & res_ready;
   assign w_ps_push = psum_wen & ~psum_full & ~clear;
   assign w_ps_pop  = w_acc & w_need_ps;
   assign w_of_push = w_pipe_drain & ~clear;
   assign w_of_pop  = out_ren & ~out_empty & ~clear;

   assign w_res_ext = {res_data[PSUM_WIDTH-1], res_data};
   assign w_ps_ext  = {w_ps_head[PSUM_WIDTH-1], w_ps_head};

   // Both operands are sign-extended by one bit, so the sum cannot overflow.
   always_comb begin
      w_pipe_nxt = w_res_ext;
      case (r_mode)
         2'b01:   w_pipe_nxt = w_res_ext + w_ps_ext;
         2'b10:   w_pipe_nxt = w_ps_ext;
         default: w_pipe_nxt = w_res_ext;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_ps_push) begin
         for (int i = 0; i < PSUM_PAR_WRITE; i++)
            r_ps_mem[ps_wrap(r_ps_wptr, i)] <= psum_din[i*PSUM_WIDTH +: PSUM_WIDTH];
      end
      if (w_of_push) r_of_mem[r_of_wptr] <= r_pipe_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ps_wptr <= '0;
         r_ps_rptr <= '0;
         r_ps_cnt  <= '0;
         r_of_wptr <= '0;
         r_of_rptr <= '0;
         r_of_cnt  <= '0;
         out_dout  <= '0;
      end else if (clear) begin
         r_ps_wptr <= '0;
         r_ps_rptr <= '0;
         r_ps_cnt  <= '0;
         r_of_wptr <= '0;
         r_of_rptr <= '0;
         r_of_cnt  <= '0;
         out_dout  <= '0;
      end else begin
         if (w_ps_push) r_ps_wptr <= ps_wrap(r_ps_wptr, PSUM_PAR_WRITE);
         if (w_ps_pop)  r_ps_rptr <= ps_wrap(r_ps_rptr, 1);
         r_ps_cnt <= r_ps_cnt + (w_ps_push ? PS_CW'(PSUM_PAR_WRITE) : PS_CW'(0))
                              - (w_ps_pop ? PS_CW'(1) : PS_CW'(0));
         if (w_of_push) r_of_wptr <= of_wrap(r_of_wptr, 1);
         if (w_of_pop) begin
            r_of_rptr <= of_wrap(r_of_rptr, OUT_PAR_READ);
            for (int i = 0; i < OUT_PAR_READ; i++)
               out_dout[i*OW +: OW] <= r_of_mem[of_wrap(r_of_rptr, i)];
         end
         r_of_cnt <= r_of_cnt + (w_of_push ? OF_CW'(1) : OF_CW'(0))
                              - (w_of_pop ? OF_CW'(OUT_PAR_READ) : OF_CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_pipe_vld  <= 1'b0;
         r_pipe_data <= '0;
      end else if (clear) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_pipe_vld  <= 1'b0;
         r_pipe_data <= '0;
      end else begin
         if (w_acc) begin
            r_pipe_vld  <= 1'b1;
            r_pipe_data <= w_pipe_nxt;
            r_cnt       <= r_cnt + 1'b1;
         end else if (w_pipe_drain) begin
            r_pipe_vld  <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_len   <= len;
                  r_cnt   <= '0;
                  r_state <= (len == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN:   if (r_cnt == r_len) r_state <= S_DRAIN;
            S_DRAIN: if (!r_pipe_vld) r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench: instance A (defaults, 4-deep output FIFO) for run modes, backpressure,
// reset and clear; instance B (2-wide psum write, 2-wide read, depth 4) for width and wrap.
module tb_psum_accum_buffer;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic        a_clear, a_start, a_psum_wen, a_psum_full, a_psum_empty;
   logic [1:0]  a_mode;
   logic [7:0]  a_len;
   logic [15:0] a_psum_din, a_res_data;
   logic        a_res_valid, a_res_ready, a_out_ren, a_out_full, a_out_empty, a_busy, a_done;
   logic [16:0] a_out_dout;

   logic        b_clear, b_start, b_psum_wen, b_psum_full, b_psum_empty;
   logic [1:0]  b_mode;
   logic [7:0]  b_len;
   logic [31:0] b_psum_din;
   logic [15:0] b_res_data;
   logic        b_res_valid, b_res_ready, b_out_ren, b_out_full, b_out_empty, b_busy, b_done;
   logic [33:0] b_out_dout;

   psum_accum_buffer #(.PSUM_WIDTH(16), .PSUM_PAR_WRITE(1), .PSUM_DEPTH(16),
                       .OUT_PAR_READ(1), .OUT_DEPTH(4), .CNT_W(8)) u_dut_a (
      .clk(clk), .rstn(rstn), .clear(a_clear), .start(a_start), .mode(a_mode), .len(a_len),
      .psum_wen(a_psum_wen), .psum_din(a_psum_din), .psum_full(a_psum_full),
      .psum_empty(a_psum_empty), .res_valid(a_res_valid), .res_data(a_res_data),
      .res_ready(a_res_ready), .out_ren(a_out_ren), .out_dout(a_out_dout),
      .out_full(a_out_full), .out_empty(a_out_empty), .busy(a_busy), .done(a_done));

   psum_accum_buffer #(.PSUM_WIDTH(16), .PSUM_PAR_WRITE(2), .PSUM_DEPTH(4),
                       .OUT_PAR_READ(2), .OUT_DEPTH(4), .CNT_W(8)) u_dut_b (
      .clk(clk), .rstn(rstn), .clear(b_clear), .start(b_start), .mode(b_mode), .len(b_len),
      .psum_wen(b_psum_wen), .psum_din(b_psum_din), .psum_full(b_psum_full),
      .psum_empty(b_psum_empty), .res_valid(b_res_valid), .res_data(b_res_data),
      .res_ready(b_res_ready), .out_ren(b_out_ren), .out_dout(b_out_dout),
      .out_full(b_out_full), .out_empty(b_out_empty), .busy(b_busy), .done(b_done));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [15:0] a_vals[$];
   logic [15:0] a_ps_pend[$];
   logic [16:0] a_got[$];
   int          a_idx, a_done_cnt;
   bit          a_prev_ren, a_start_pulse, a_clear_pulse, a_ps_nogate;
   logic        a_busy_at_done;

   logic [15:0] b_vals[$];
   logic [31:0] b_ps_pend[$];
   logic [33:0] b_got[$];
   int          b_idx, b_done_cnt;
   bit          b_prev_ren, b_start_pulse, b_ps_nogate;

   function automatic logic [16:0] a_got_at(input int i);
      if (i < a_got.size()) return a_got[i];
      return 17'h0;
   endfunction

   function automatic logic [33:0] b_got_at(input int i);
      if (i < b_got.size()) return b_got[i];
      return 34'h0;
   endfunction

   task automatic a_new();
      a_vals.delete(); a_got.delete(); a_ps_pend.delete();
      a_idx = 0; a_done_cnt = 0; a_busy_at_done = 1'b1;
   endtask

   task automatic b_new();
      b_vals.delete(); b_got.delete(); b_ps_pend.delete();
      b_idx = 0; b_done_cnt = 0;
   endtask

   // One cycle for instance A: capture last read, drive inputs at negedge, note acceptance.
   task automatic a_step(input bit rd_en);
      @(negedge clk);
      if (a_prev_ren) a_got.push_back(a_out_dout);
      a_start = a_start_pulse; a_clear = a_clear_pulse;
      a_start_pulse = 1'b0; a_clear_pulse = 1'b0;
      if (a_ps_pend.size() > 0 && (!a_psum_full || a_ps_nogate)) begin
         a_psum_wen = 1'b1; a_psum_din = a_ps_pend.pop_front();
      end else a_psum_wen = 1'b0;
      if (a_idx < a_vals.size()) begin
         a_res_valid = 1'b1; a_res_data = a_vals[a_idx];
      end else a_res_valid = 1'b0;
      a_out_ren = rd_en && !a_out_empty;
      a_prev_ren = a_out_ren;
      #1;
      if (a_res_valid && a_res_ready) a_idx++;
      if (a_done) begin a_done_cnt++; a_busy_at_done = a_busy; end
   endtask

   task automatic a_run(input int n, input bit rd_en);
      for (int i = 0; i < n; i++) a_step(rd_en);
   endtask

   // Instance B reads are not gated, so a read against an empty FIFO can be attempted.
   task automatic b_step(input bit rd_en);
      @(negedge clk);
      if (b_prev_ren) b_got.push_back(b_out_dout);
      b_start = b_start_pulse; b_start_pulse = 1'b0;
      if (b_ps_pend.size() > 0 && (!b_psum_full || b_ps_nogate)) begin
         b_psum_wen = 1'b1; b_psum_din = b_ps_pend.pop_front();
      end else b_psum_wen = 1'b0;
      if (b_idx < b_vals.size()) begin
         b_res_valid = 1'b1; b_res_data = b_vals[b_idx];
      end else b_res_valid = 1'b0;
      b_out_ren = rd_en;
      b_prev_ren = rd_en && !b_out_empty;
      #1;
      if (b_res_valid && b_res_ready) b_idx++;
      if (b_done) b_done_cnt++;
   endtask

   task automatic b_run(input int n, input bit rd_en);
      for (int i = 0; i < n; i++) b_step(rd_en);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  bad;
      bit  any_ready;
      logic [33:0] e;
      a_clear = 0; a_start = 0; a_mode = 0; a_len = 0; a_psum_wen = 0; a_psum_din = 0;
      a_res_valid = 0; a_res_data = 0; a_out_ren = 0;
      b_clear = 0; b_start = 0; b_mode = 0; b_len = 0; b_psum_wen = 0; b_psum_din = 0;
      b_res_valid = 0; b_res_data = 0; b_out_ren = 0;
      a_prev_ren = 0; a_start_pulse = 0; a_clear_pulse = 0; a_ps_nogate = 0;
      b_prev_ren = 0; b_start_pulse = 0; b_ps_nogate = 0;
      a_new(); b_new();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk_eq("rst_psum_empty", a_psum_empty, 1);
      chk_eq("rst_out_empty", a_out_empty, 1);
      chk_eq("rst_flags_full", {a_psum_full, a_out_full}, 0);
      chk_eq("rst_ready_busy_done", {a_res_ready, a_busy, a_done}, 0);
      chk_eq("rst_dout", a_out_dout, 0);
      @(negedge clk);
      rstn = 1'b1;

      // bypass run
      a_new(); a_vals = '{16'd5, 16'hFFFE, 16'd7};
      a_mode = 2'b00; a_len = 8'd3; a_start_pulse = 1;
      a_run(25, 1);
      chk_eq("byp_count", a_got.size(), 3);
      chk_eq("byp_w0", a_got_at(0), 17'd5);
      chk_eq("byp_w1", a_got_at(1), 17'h1FFFE);
      chk_eq("byp_w2", a_got_at(2), 17'd7);
      chk_eq("byp_done_pulses", a_done_cnt, 1);
      chk_eq("byp_busy_at_done", a_busy_at_done, 0);

      // accumulate run
      a_new(); a_ps_pend = '{16'd10, 16'd20};
      a_run(3, 0);
      chk_eq("acc_psum_loaded", a_psum_empty, 0);
      a_vals = '{16'd1, 16'hFFE2};
      a_mode = 2'b01; a_len = 8'd2; a_start_pulse = 1;
      a_run(20, 1);
      chk_eq("acc_count", a_got.size(), 2);
      chk_eq("acc_w0", a_got_at(0), 17'd11);
      chk_eq("acc_w1", a_got_at(1), 17'h1FFF6);
      chk_eq("acc_psum_empty", a_psum_empty, 1);
      chk_eq("acc_done_pulses", a_done_cnt, 1);

      // accumulate with no psum available, then clear out of RUN
      a_new(); a_vals = '{16'd3, 16'd4};
      a_mode = 2'b01; a_len = 8'd2; a_start_pulse = 1;
      a_step(1);
      any_ready = 0;
      for (int i = 0; i < 8; i++) begin a_step(1); any_ready |= a_res_ready; end
      chk_eq("acc_empty_ready", any_ready, 0);
      chk_eq("acc_empty_busy", a_busy, 1);
      chk_eq("acc_empty_accepted", a_idx, 0);
      a_clear_pulse = 1;
      a_run(2, 0);
      chk_eq("clear_busy", a_busy, 0);

      // psum pass-through with a full psum FIFO and a dropped write
      a_new();
      for (int i = 0; i < 16; i++) a_ps_pend.push_back(16'(200 + i));
      a_run(18, 0);
      chk_eq("m10_psum_full", a_psum_full, 1);
      a_ps_nogate = 1; a_ps_pend.push_back(16'd999);
      a_step(0);
      a_ps_nogate = 0;
      for (int i = 0; i < 16; i++) a_vals.push_back(16'h7777);
      a_mode = 2'b10; a_len = 8'd16; a_start_pulse = 1;
      a_run(45, 1);
      chk_eq("m10_count", a_got.size(), 16);
      bad = 0;
      for (int i = 0; i < 16; i++) if (a_got_at(i) !== 17'(200 + i)) bad++;
      chk_eq("m10_order", bad, 0);
      chk_eq("m10_psum_empty", a_psum_empty, 1);

      // backpressure
      a_new(); a_vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
      a_mode = 2'b00; a_len = 8'd6; a_start_pulse = 1;
      a_run(15, 0);
      chk_eq("bp_out_full", a_out_full, 1);
      chk_eq("bp_accepted", a_idx, 5);
      chk_eq("bp_busy", a_busy, 1);
      a_run(25, 1);
      chk_eq("bp_count", a_got.size(), 6);
      bad = 0;
      for (int i = 0; i < 6; i++) if (a_got_at(i) !== 17'(i + 1)) bad++;
      chk_eq("bp_order", bad, 0);
      chk_eq("bp_done_pulses", a_done_cnt, 1);

      // reset mid-run
      a_new(); a_vals = '{16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};
      a_mode = 2'b00; a_len = 8'd8; a_start_pulse = 1;
      a_run(5, 0);
      a_step(1);
      a_step(0);
      chk_eq("mid_pre_dout", a_out_dout, 17'd8);
      chk_eq("mid_pre_busy", a_busy, 1);
      a_vals.delete(); a_prev_ren = 0;
      rstn = 1'b0;
      #1;
      chk_eq("mid_rst_busy_done_ready", {a_busy, a_done, a_res_ready}, 0);
      chk_eq("mid_rst_empties", {a_psum_empty, a_out_empty}, 2'b11);
      chk_eq("mid_rst_fulls", {a_psum_full, a_out_full}, 0);
      chk_eq("mid_rst_dout", a_out_dout, 0);
      a_run(3, 0);
      rstn = 1'b1;
      a_run(6, 0);
      chk_eq("mid_rst_no_done", a_done_cnt, 0);
      chk_eq("mid_rst_idle", a_busy, 0);

      // clear together with start
      a_new(); a_mode = 2'b00; a_len = 8'd3; a_start_pulse = 1; a_clear_pulse = 1;
      a_step(0);
      a_step(0);
      chk_eq("clr_start_busy", a_busy, 0);
      chk_eq("clr_start_done", a_done, 0);

      // zero-length run
      a_new(); a_len = 8'd0; a_start_pulse = 1;
      a_step(0);
      a_step(0);
      chk_eq("len0_done", a_done, 1);
      chk_eq("len0_busy", a_busy, 0);
      a_step(0);
      chk_eq("len0_done_end", a_done, 0);
      chk_eq("len0_no_output", a_out_empty, 1);

      // instance B: two-wide writes, third dropped when full
      b_new(); b_ps_nogate = 1;
      b_ps_pend = '{{16'd2, 16'd1}, {16'd4, 16'd3}, {16'd6, 16'd5}};
      b_run(4, 0);
      b_ps_nogate = 0;
      chk_eq("pw_psum_full", b_psum_full, 1);
      for (int i = 0; i < 4; i++) b_vals.push_back(16'h0);
      b_mode = 2'b10; b_len = 8'd4; b_start_pulse = 1;
      b_run(30, 1);
      chk_eq("pw_count", b_got.size(), 2);
      chk_eq("pw_r0", b_got_at(0), {17'd2, 17'd1});
      chk_eq("pw_r1", b_got_at(1), {17'd4, 17'd3});
      chk_eq("pw_dropped", b_psum_empty, 1);

      // two-wide read with a single stored word
      b_new(); b_vals = '{16'd9};
      b_mode = 2'b00; b_len = 8'd1; b_start_pulse = 1;
      b_run(10, 0);
      chk_eq("pr_one_word_empty", b_out_empty, 1);
      b_step(1);
      b_step(0);
      chk_eq("pr_ignored_dout", b_out_dout, {17'd4, 17'd3});
      b_new(); b_vals = '{16'd10};
      b_mode = 2'b00; b_len = 8'd1; b_start_pulse = 1;
      b_run(10, 0);
      chk_eq("pr_two_words", b_out_empty, 0);
      b_step(1);
      b_step(0);
      chk_eq("pr_pair", b_got_at(0), {17'd10, 17'd9});

      // sustained traffic, pointers wrap three times
      b_new();
      for (int k = 0; k < 6; k++) b_ps_pend.push_back({16'(101 + 2*k), 16'(100 + 2*k)});
      for (int i = 0; i < 12; i++) b_vals.push_back(16'h0);
      b_mode = 2'b10; b_len = 8'd12; b_start_pulse = 1;
      b_run(80, 1);
      chk_eq("wrap_count", b_got.size(), 6);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         e = {17'(101 + 2*k), 17'(100 + 2*k)};
         if (b_got_at(k) !== e) bad++;
      end
      chk_eq("wrap_order", bad, 0);
      chk_eq("wrap_done_pulses", b_done_cnt, 1);
      chk_eq("wrap_empties", {b_psum_empty, b_out_empty}, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
